// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive FIFO.
//   PDATA_WIDTH  default character width
//   DEPTH        default FIFO depth (power of two)
//   rx_entry_t   one stored character {bi, fe, pe, data}
//   TRIG_*       FCR trigger-select encodings and trig_level() decoder
package uart_pkg;

    localparam int PDATA_WIDTH = 8;
    localparam int DEPTH       = 16;

    typedef struct packed {
        logic                   bi;
        logic                   fe;
        logic                   pe;
        logic [PDATA_WIDTH-1:0] data;
    } rx_entry_t;

    localparam logic [1:0] TRIG_1  = 2'b00;
    localparam logic [1:0] TRIG_4  = 2'b01;
    localparam logic [1:0] TRIG_8  = 2'b10;
    localparam logic [1:0] TRIG_14 = 2'b11;

    // Decode the FCR trigger select into an entry count.
    function automatic int unsigned trig_level(input logic [1:0] sel);
        case (sel)
            TRIG_1:  return 32'd1;
            TRIG_4:  return 32'd4;
            TRIG_8:  return 32'd8;
            TRIG_14: return 32'd14;
            default: return 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH register array, one synchronous write port
// and one asynchronous read port. The array itself is not reset; the
// controller never presents an entry that has not been written.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16550-style receive FIFO with show-ahead head presentation,
// sticky overrun, LSR bit-7 error tracking, trigger-level compare and an
// optional character-timeout detector.
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN (character timeout).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push, push_data, push_pe/fe/bi   character from the receiver
//   pop                      host RBR read
//   fifo_clr                 FCR receiver-FIFO reset
//   lsr_rd                   host LSR read (clears oe)
//   trig_lvl                 FCR trigger select (1/4/8/14)
//   char_tick                one pulse per character time
//   rd_data, rd_pe/fe/bi     head entry
//   dr, oe, fifo_err, trig_hit, timeout, count   status
module uart_rx_fifo #(
    parameter int DEPTH       = uart_pkg::DEPTH,
    parameter int PDATA_WIDTH = uart_pkg::PDATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PDATA_WIDTH-1:0]   push_data,
    input  logic                     push_pe,
    input  logic                     push_fe,
    input  logic                     push_bi,
    input  logic                     pop,
    input  logic                     fifo_clr,
    input  logic                     lsr_rd,
    input  logic [1:0]               trig_lvl,
    input  logic                     char_tick,
    output logic [PDATA_WIDTH-1:0]   rd_data,
    output logic                     rd_pe,
    output logic                     rd_fe,
    output logic                     rd_bi,
    output logic                     dr,
    output logic                     oe,
    output logic                     fifo_err,
    output logic                     trig_hit,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   count
);

    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PDATA_WIDTH + 3;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
    logic          oe_q, oe_d;
    logic [EW-1:0] last_q, last_d;
    logic [EW-1:0] head_s, wr_entry_s, rd_entry_s;
    logic          full_s, empty_s, push_ok_s, pop_ok_s, overrun_s;

    assign full_s     = (count_q == CW'(DEPTH));
    assign empty_s    = (count_q == {CW{1'b0}});
    // A full FIFO still accepts a push when a pop frees the head slot.
    assign push_ok_s  = push & ~fifo_clr & (~full_s | pop);
    assign pop_ok_s   = pop & ~fifo_clr & ~empty_s;
    assign overrun_s  = push & ~fifo_clr & full_s & ~pop;
    assign wr_entry_s = {push_bi, push_fe, push_pe, push_data};

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (wr_ptr_q),
        .wdata (wr_entry_s),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Next-state for pointers, occupancy, error-entry count, overrun and last-read entry.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        last_d    = last_q;
        if (fifo_clr) begin
            wr_ptr_d  = {AW{1'b0}};
            rd_ptr_d  = {AW{1'b0}};
            count_d   = {CW{1'b0}};
            err_cnt_d = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                last_d   = head_s;
            end else begin
                rd_ptr_d = rd_ptr_q;
                last_d   = last_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case ({push_ok_s & (|wr_entry_s[EW-1:EW-3]), pop_ok_s & (|head_s[EW-1:EW-3])})
                2'b10:   err_cnt_d = err_cnt_q + CW'(1);
                2'b01:   err_cnt_d = err_cnt_q - CW'(1);
                default: err_cnt_d = err_cnt_q;
            endcase
        end
        // A fresh overrun wins over a simultaneous LSR read.
        if (overrun_s) begin
            oe_d = 1'b1;
        end else if (lsr_rd) begin
            oe_d = 1'b0;
        end else begin
            oe_d = oe_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            err_cnt_q <= {CW{1'b0}};
            oe_q      <= 1'b0;
            last_q    <= {EW{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
            oe_q      <= oe_d;
            last_q    <= last_d;
        end
    end

    // Show-ahead head while data is resident; otherwise hold the last entry read.
    always_comb begin
        if (!empty_s) begin
            rd_entry_s = head_s;
        end else begin
            rd_entry_s = last_q;
        end
    end

    assign rd_data  = rd_entry_s[PDATA_WIDTH-1:0];
    assign rd_pe    = rd_entry_s[EW-3];
    assign rd_fe    = rd_entry_s[EW-2];
    assign rd_bi    = rd_entry_s[EW-1];
    assign dr       = ~empty_s;
    assign oe       = oe_q;
    assign fifo_err = (err_cnt_q != {CW{1'b0}});
    assign trig_hit = (32'(count_q) >= trig_level(trig_lvl));
    assign count    = count_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [2:0] idle_q, idle_d;
    logic       timeout_q, timeout_d;

    // Idle character-time counter; saturates at the timeout threshold of 4.
    always_comb begin
        if (fifo_clr || push || pop || empty_s) begin
            idle_d = 3'd0;
        end else if (char_tick && (idle_q != 3'd4)) begin
            idle_d = idle_q + 3'd1;
        end else begin
            idle_d = idle_q;
        end
        if (fifo_clr || push || pop) begin
            timeout_d = 1'b0;
        end else if (idle_d == 3'd4) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_char_tick_s;
    assign unused_char_tick_s = char_tick;
    assign timeout            = 1'b0;
`endif

endmodule
